scr1_imem_sram_responder: RTL and testbench
===========================================

SCR1_IMEM_SRAM_RESPONDER -- requirements
Module: scr1_imem_sram_responder

Interface
REQ-001 SHALL have parameter SCR1_MEM_BASE, default `SCR1_IMEM_AWIDTH'h00010000, byte base address of the served window, 4-byte aligned.
REQ-002 SHALL have parameter SCR1_MEM_SIZE, default 65536, window size in bytes, power of two and at least 4.
REQ-003 SHALL have parameter SCR1_WAIT_STATES, default 0, range 0..15, extra cycles inserted before an OK response.
REQ-004 Clocking: one clock, and the reset is asynchronous and active-low.
REQ-005 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: imem_req_ack  output  1  request accepted this cycle (combinational).
REQ-008 Port: imem_req  input  1  core request valid.
REQ-009 Port: imem_cmd  input  type_scr1_mem_cmd_e  command.
REQ-010 Port: imem_addr  input  `SCR1_IMEM_AWIDTH  byte address.
REQ-011 Port: imem_rdata  output  `SCR1_IMEM_DWIDTH  read data, valid when imem_resp = SCR1_MEM_RESP_RDY_OK.
REQ-012 Port: imem_resp  output  type_scr1_mem_resp_e  response.
REQ-013 Port: sram_en  output  1  synchronous SRAM read enable.
REQ-014 Port: sram_addr  output  $clog2(SCR1_MEM_SIZE/4)  SRAM word index.
REQ-015 Port: sram_rdata  input  `SCR1_IMEM_DWIDTH  SRAM data, valid one cycle after sram_en.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 Acceptance: imem_req_ack = 1 in IDLE or in RESP, and 0 in WAIT; a transfer occurs when imem_req & imem_req_ack.
REQ-018 In the cycle of a transfer, SHALL latch the word index, imem_addr[$clog2(SCR1_MEM_SIZE)-1:2], and an error flag.
REQ-019 Error flag SHALL be set when any of these holds: imem_cmd != SCR1_MEM_CMD_RD; imem_addr[1:0] != 0; or (imem_addr - SCR1_MEM_BASE) >= SCR1_MEM_SIZE, computed as an unsigned `SCR1_IMEM_AWIDTH-bit subtraction so that addresses below the base also fail.
REQ-020 Error transfer: next state SHALL be RESP regardless of SCR1_WAIT_STATES; no sram_en is issued.
REQ-021 OK transfer with SCR1_WAIT_STATES = 0: sram_en = 1 in the transfer cycle with sram_addr taken from imem_addr; next state RESP.
REQ-022 OK transfer with SCR1_WAIT_STATES = N > 0: next state WAIT with counter = N-1.
REQ-023 In WAIT: the counter decrements each cycle; when the counter = 0, sram_en = 1 with sram_addr taken from the latched index, and next state is RESP.
REQ-024 Outside the cycles defined in REQ-021 and REQ-023, sram_en SHALL be 0; sram_addr is don't-care there.
REQ-025 Latency: the response SHALL appear exactly 1+N cycles after an OK transfer, and exactly 1 cycle after an error transfer.
REQ-026 RESP lasts exactly one cycle; imem_resp = RDY_OK with imem_rdata = sram_rdata, or RDY_ER with imem_rdata = 0.
REQ-027 In IDLE and WAIT, imem_resp SHALL be SCR1_MEM_RESP_NOTRDY and imem_rdata SHALL be 0.
REQ-028 Back-to-back: a transfer in the RESP cycle SHALL follow REQ-018..REQ-023 in that same cycle.
REQ-029 With N = 0, back-to-back transfers SHALL sustain one response per cycle.
REQ-030 A RESP cycle with no transfer SHALL return the FSM to IDLE.
REQ-031 imem_req deasserting while in WAIT SHALL NOT abort the outstanding access; its response is still produced.
REQ-032 Only one transfer SHALL be outstanding at any time; no request is queued.

Reset
REQ-033 rst_n = 0 SHALL immediately force: state IDLE, counter 0, latched index 0, error flag 0, imem_resp NOTRDY, imem_rdata 0, sram_en 0.
REQ-034 Reset asserted mid-operation (WAIT or RESP) SHALL discard the pending response; no response is emitted after reset release.
REQ-035 First transfer SHALL be possible in the first clock edge after rst_n deasserts.

Verification
REQ-036 N=0, read at 0x00010008 with the SRAM holding 0xDEADBEEF at word 2 -> sram_en=1 and sram_addr=2 in cycle T; RDY_OK with rdata 0xDEADBEEF at T+1.
REQ-037 N=3, read at 0x00010000 -> imem_req_ack=0 for cycles T+1..T+3; sram_en=1 at T+3 only; RDY_OK at T+4.
REQ-038 N=2; reads at 0x0000FFFC, 0x00020000 and 0x00010002, plus a WR at 0x00010000 -> each gives RDY_ER at T+1, rdata 0, and sram_en never asserted.
REQ-039 N=0, imem_req held high with addresses 0x10000, 0x10004, 0x10008 -> imem_req_ack=1 every cycle and three consecutive RDY_OK cycles with the matching data.
REQ-040 N=5, rst_n pulsed low at T+2 -> outputs are at reset values immediately, and no RDY_OK or RDY_ER appears afterwards without a new transfer.
REQ-041 Random bench: every transfer yields exactly one non-NOTRDY response at the latency required by REQ-025, and imem_req_ack is never asserted in WAIT.

Source files
------------

// File: rtl/scr1_imem_sram_responder.sv
// Instruction-memory responder for the SCR1 IMEM port, backed by a synchronous SRAM.
// Accepts one read at a time, adds programmable wait states and flags bad commands or addresses.
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif
`ifndef SCR1_MEMIF_TYPES_DEFINED
`define SCR1_MEMIF_TYPES_DEFINED
typedef enum logic {
  SCR1_MEM_CMD_RD = 1'b0,
  SCR1_MEM_CMD_WR = 1'b1
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
  SCR1_MEM_RESP_NOTRDY = 2'b00,
  SCR1_MEM_RESP_RDY_OK = 2'b01,
  SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;
`endif

module scr1_imem_sram_responder #(
  parameter logic [`SCR1_IMEM_AWIDTH-1:0] SCR1_MEM_BASE    = `SCR1_IMEM_AWIDTH'h00010000,
  parameter int unsigned                  SCR1_MEM_SIZE    = 65536,
  parameter int unsigned                  SCR1_WAIT_STATES = 0,
  localparam int unsigned                 IDX_W = (SCR1_MEM_SIZE > 4) ? $clog2(SCR1_MEM_SIZE / 4) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req_ack,
  input  logic                          imem_req,
  input  type_scr1_mem_cmd_e            imem_cmd,
  input  logic [`SCR1_IMEM_AWIDTH-1:0]  imem_addr,
  output logic [`SCR1_IMEM_DWIDTH-1:0]  imem_rdata,
  output type_scr1_mem_resp_e           imem_resp,
  output logic                          sram_en,
  output logic [IDX_W-1:0]              sram_addr,
  input  logic [`SCR1_IMEM_DWIDTH-1:0]  sram_rdata
);

  localparam int unsigned          AW        = `SCR1_IMEM_AWIDTH;
  localparam logic [AW-1:0]        SIZE_AW   = AW'(SCR1_MEM_SIZE);
  localparam logic [3:0]           WAIT_LAST = (SCR1_WAIT_STATES == 0) ? 4'd0 : 4'(SCR1_WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e          state;
  state_e          state_next;
  logic [3:0]      cnt;
  logic [3:0]      cnt_next;
  logic [IDX_W-1:0] idx;
  logic            err;
  logic            xfer;
  logic            err_now;
  logic [AW-1:0]   offset;

  // Below-base addresses wrap to large offsets, so a single compare covers both window edges.
  assign offset  = imem_addr - SCR1_MEM_BASE;
  assign err_now = (imem_cmd != SCR1_MEM_CMD_RD) || (imem_addr[1:0] != 2'b00) || (offset >= SIZE_AW);
  assign xfer    = imem_req & imem_req_ack;

  // Next-state, acceptance and SRAM strobe decode.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    imem_req_ack = 1'b0;
    sram_en      = 1'b0;
    sram_addr    = idx;
    case (state)
      IDLE, RESP: begin
        imem_req_ack = 1'b1;
        if (xfer) begin
          if (err_now) begin
            state_next = RESP;
          end else if (SCR1_WAIT_STATES == 0) begin
            sram_en    = 1'b1;
            sram_addr  = imem_addr[IDX_W+1:2];
            state_next = RESP;
          end else begin
            cnt_next   = WAIT_LAST;
            state_next = WAIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          sram_en    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State, wait counter and per-transfer context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (xfer) begin
        idx <= imem_addr[IDX_W+1:2];
        err <= err_now;
      end else begin
        idx <= idx;
        err <= err;
      end
    end
  end

  // Response follows the state directly so reset clears it without waiting for a clock edge.
  always_comb begin
    imem_resp  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata = '0;
    if (state == RESP) begin
      if (err) begin
        imem_resp = SCR1_MEM_RESP_RDY_ER;
      end else begin
        imem_resp  = SCR1_MEM_RESP_RDY_OK;
        imem_rdata = sram_rdata;
      end
    end else begin
      imem_resp  = SCR1_MEM_RESP_NOTRDY;
      imem_rdata = '0;
    end
  end

endmodule

// File: tb/tb_scr1_imem_sram_responder.sv
// Directed bench: four responders (0, 3, 2 and 5 wait states) share one request bus,
// each with its own behavioural SRAM; each scenario checks the instance it targets.
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif
`ifndef SCR1_MEMIF_TYPES_DEFINED
`define SCR1_MEMIF_TYPES_DEFINED
typedef enum logic {
  SCR1_MEM_CMD_RD = 1'b0,
  SCR1_MEM_CMD_WR = 1'b1
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
  SCR1_MEM_RESP_NOTRDY = 2'b00,
  SCR1_MEM_RESP_RDY_OK = 2'b01,
  SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;
`endif

module tb_scr1_imem_sram_responder;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req;
  type_scr1_mem_cmd_e cmd;
  logic [31:0]        addr;

  logic        ack       [4];
  logic [31:0] rdata     [4];
  logic [1:0]  resp      [4];
  logic        sram_en   [4];
  logic [13:0] sram_addr [4];

  logic [31:0] mem [16];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] srd;
    always @(posedge clk) if (sram_en[g]) srd <= mem[sram_addr[g][3:0]];
    scr1_imem_sram_responder #(
      .SCR1_WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 2 : 5)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req_ack (ack[g]),
      .imem_req     (req),
      .imem_cmd     (cmd),
      .imem_addr    (addr),
      .imem_rdata   (rdata[g]),
      .imem_resp    (resp[g]),
      .sram_en      (sram_en[g]),
      .sram_addr    (sram_addr[g]),
      .sram_rdata   (srd)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drain();
    req = 1'b0;
    repeat (8) tick();
  endtask

  logic [31:0] err_addr [4];
  logic        err_wr   [4];

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    cmd   = SCR1_MEM_CMD_RD;
    addr  = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = i * 32'h01010101;
    mem[0] = 32'h0BADF00D;
    mem[1] = 32'h12345678;
    mem[2] = 32'hDEADBEEF;
    err_addr = '{32'h0000FFFC, 32'h00020000, 32'h00010002, 32'h00010000};
    err_wr   = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Reset values
    #2;
    check("rst_resp",  resp[0],    SCR1_MEM_RESP_NOTRDY);
    check("rst_rdata", rdata[0],   32'h0);
    check("rst_en",    sram_en[0], 1'b0);
    check("rst_ack3",  ack[3],     1'b1);

    // N=0 single read, launched in the cycle reset is released
    tick();
    rst_n = 1'b1;
    req   = 1'b1;
    addr  = 32'h00010008;
    mid();
    check("n0_ack",   ack[0],       1'b1);
    check("n0_en",    sram_en[0],   1'b1);
    check("n0_saddr", sram_addr[0], 32'd2);
    tick();
    req = 1'b0;
    mid();
    check("n0_resp",  resp[0],  SCR1_MEM_RESP_RDY_OK);
    check("n0_rdata", rdata[0], 32'hDEADBEEF);
    tick();
    mid();
    check("n0_idle",  resp[0],  SCR1_MEM_RESP_NOTRDY);
    drain();

    // N=3 read: ack low while waiting, strobe only in the last wait cycle
    req  = 1'b1;
    addr = 32'h00010000;
    mid();
    check("n3_ack_t", ack[1],     1'b1);
    check("n3_en_t",  sram_en[1], 1'b0);
    tick();
    req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mid();
      if (k < 4) begin
        check($sformatf("n3_ack_t%0d", k),  ack[1],     1'b0);
        check($sformatf("n3_resp_t%0d", k), resp[1],    SCR1_MEM_RESP_NOTRDY);
        check($sformatf("n3_en_t%0d", k),   sram_en[1], (k == 3) ? 1'b1 : 1'b0);
        if (k == 3) check("n3_saddr", sram_addr[1], 32'd0);
      end else begin
        check("n3_resp",  resp[1],  SCR1_MEM_RESP_RDY_OK);
        check("n3_rdata", rdata[1], 32'h0BADF00D);
        check("n3_ack_r", ack[1],   1'b1);
      end
      tick();
    end
    mid();
    check("n3_idle", resp[1], SCR1_MEM_RESP_NOTRDY);
    drain();

    // N=3: new transfer accepted in the RESP cycle of the previous one
    req  = 1'b1;
    addr = 32'h00010004;
    tick();
    req = 1'b0;
    repeat (3) tick();
    req  = 1'b1;
    addr = 32'h00010008;
    mid();
    check("b2b3_ack",   ack[1],   1'b1);
    check("b2b3_resp",  resp[1],  SCR1_MEM_RESP_RDY_OK);
    check("b2b3_rdata", rdata[1], 32'h12345678);
    tick();
    req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      mid();
      check($sformatf("b2b3_ack_t%0d", k), ack[1],     1'b0);
      check($sformatf("b2b3_en_t%0d", k),  sram_en[1], (k == 3) ? 1'b1 : 1'b0);
      tick();
    end
    mid();
    check("b2b3_resp2",  resp[1],  SCR1_MEM_RESP_RDY_OK);
    check("b2b3_rdata2", rdata[1], 32'hDEADBEEF);
    drain();

    // Error transfers on N=2 (and N=0): one-cycle RDY_ER, no SRAM access
    for (int v = 0; v < 4; v++) begin
      req  = 1'b1;
      cmd  = err_wr[v] ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
      addr = err_addr[v];
      mid();
      check($sformatf("er%0d_ack", v),  ack[2],     1'b1);
      check($sformatf("er%0d_en2", v),  sram_en[2], 1'b0);
      check($sformatf("er%0d_en0", v),  sram_en[0], 1'b0);
      tick();
      req = 1'b0;
      cmd = SCR1_MEM_CMD_RD;
      mid();
      check($sformatf("er%0d_resp2", v),  resp[2],    SCR1_MEM_RESP_RDY_ER);
      check($sformatf("er%0d_rdata2", v), rdata[2],   32'h0);
      check($sformatf("er%0d_resp0", v),  resp[0],    SCR1_MEM_RESP_RDY_ER);
      check($sformatf("er%0d_en2r", v),   sram_en[2], 1'b0);
      for (int k = 0; k < 3; k++) begin
        tick();
        mid();
        check($sformatf("er%0d_en2_%0d", v, k), sram_en[2], 1'b0);
        check($sformatf("er%0d_nr_%0d", v, k),  resp[2],    SCR1_MEM_RESP_NOTRDY);
      end
      tick();
    end
    drain();

    // N=0 back-to-back stream: one response per cycle
    req  = 1'b1;
    addr = 32'h00010000;
    mid();
    check("s0_ack",   ack[0],       1'b1);
    check("s0_en",    sram_en[0],   1'b1);
    check("s0_saddr", sram_addr[0], 32'd0);
    tick();
    addr = 32'h00010004;
    mid();
    check("s1_ack",   ack[0],       1'b1);
    check("s1_saddr", sram_addr[0], 32'd1);
    check("s1_resp",  resp[0],      SCR1_MEM_RESP_RDY_OK);
    check("s1_rdata", rdata[0],     32'h0BADF00D);
    tick();
    addr = 32'h00010008;
    mid();
    check("s2_ack",   ack[0],       1'b1);
    check("s2_saddr", sram_addr[0], 32'd2);
    check("s2_resp",  resp[0],      SCR1_MEM_RESP_RDY_OK);
    check("s2_rdata", rdata[0],     32'h12345678);
    tick();
    req = 1'b0;
    mid();
    check("s3_resp",  resp[0],    SCR1_MEM_RESP_RDY_OK);
    check("s3_rdata", rdata[0],   32'hDEADBEEF);
    check("s3_en",    sram_en[0], 1'b0);
    tick();
    mid();
    check("s4_idle",  resp[0],    SCR1_MEM_RESP_NOTRDY);
    drain();

    // N=5: reset pulsed while waiting discards the pending response
    req  = 1'b1;
    addr = 32'h00010004;
    mid();
    check("rw_ack_t", ack[3], 1'b1);
    tick();
    req = 1'b0;
    mid();
    check("rw_ack_wait", ack[3], 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("rw_resp",  resp[3],    SCR1_MEM_RESP_NOTRDY);
    check("rw_rdata", rdata[3],   32'h0);
    check("rw_en",    sram_en[3], 1'b0);
    check("rw_ack",   ack[3],     1'b1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mid();
      check($sformatf("rw_quiet_%0d", k), resp[3], SCR1_MEM_RESP_NOTRDY);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
